// File: rtl/bcd_display_scan.sv
// -----------------------------------------------------------------------------
// bcd_display_scan
//
// Display-side consumer of the calculator's display feed. Takes a 16-bit word
// of four BCD digits plus a one-cycle scan enable from the multiplexor and
// drives a 4-digit multiplexed 7-segment display.
//
// A whole frame is latched at once, at the moment the scan wraps back to
// digit0, so a value that changes mid-scan never shows half old and half new
// digits. Between consecutive digits the block can insert GUARD_TICKS scan
// slots with every anode off. This stops the previous digit's segments from
// ghosting onto the next anode while the drivers settle.
//
// Parameters
//   GUARD_TICKS       all-off scan slots between consecutive digits (0 = none)
//   ANODE_ACTIVE_LOW  1: an enabled anode is driven 0, 0: it is driven 1
//   SEG_ACTIVE_LOW    1: a lit segment is driven 0,   0: it is driven 1
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          nonzero digit of the frame are blanked. Their
//                          anode is still scanned in its slot. Digit0 is
//                          always shown, and invalid nibbles (A-F) count as
//                          nonzero. When undefined, all four digits are
//                          always decoded and shown.
//
// Ports
//   clk         in   1   system clock, shared with the multiplexor
//   rst         in   1   asynchronous, active-high reset
//   next_data   in   1   scan tick; each clk cycle with next_data=1 is one tick
//   data_shown  in   16  digits, [3:0]=digit0 (rightmost) .. [15:12]=digit3
//   anodes      out  4   digit enables, bit i = digit i, at most one active
//   segments    out  7   {g,f,e,d,c,b,a}
//   frame_done  out  1   one-clk pulse when a new frame is latched
//
// Timing: every output is a flop. A tick on edge N shows its result after
// edge N. A full frame takes 4*(1+GUARD_TICKS) ticks.
// -----------------------------------------------------------------------------
module bcd_display_scan #(
  parameter int unsigned GUARD_TICKS      = 1,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        next_data,
  input  logic [15:0] data_shown,
  output logic [3:0]  anodes,
  output logic [6:0]  segments,
  output logic        frame_done
);

  // Guard counter only needs to hold GUARD_TICKS-1. Keep at least one bit so
  // the declaration stays legal when GUARD_TICKS is 0 or 1.
  localparam int unsigned GCW = (GUARD_TICKS > 1) ? $clog2(GUARD_TICKS) : 1;
  localparam logic [GCW-1:0] GUARD_LOAD =
    (GUARD_TICKS > 0) ? GCW'(GUARD_TICKS - 1) : '0;

  // Physical "off" levels after polarity is applied.
  localparam logic [3:0] ANODE_OFF = ANODE_ACTIVE_LOW ? 4'hF  : 4'h0;
  localparam logic [6:0] SEG_OFF   = SEG_ACTIVE_LOW   ? 7'h7F : 7'h00;

  typedef enum logic {
    ST_SHOW  = 1'b0,   // one digit is lit
    ST_GUARD = 1'b1    // all anodes off, counting guard slots
  } state_t;

  // ---------------------------------------------------------------------------
  // Segment decode. The result is active-high (1 = segment lit), in the order
  // {g,f,e,d,c,b,a}. Six and nine keep their tails (a and d). Seven lights
  // a, b and c only. Any non-BCD nibble shows a dash so a corrupt feed is
  // visible instead of looking like a number.
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] seg_decode(input logic [3:0] i_digit);
    logic [6:0] lit;
    case (i_digit)
      4'd0:    lit = 7'b0111111;
      4'd1:    lit = 7'b0000110;
      4'd2:    lit = 7'b1011011;
      4'd3:    lit = 7'b1001111;
      4'd4:    lit = 7'b1100110;
      4'd5:    lit = 7'b1101101;
      4'd6:    lit = 7'b1111101;
      4'd7:    lit = 7'b0000111;
      4'd8:    lit = 7'b1111111;
      4'd9:    lit = 7'b1101111;
      default: lit = 7'b1000000;
    endcase
    return lit;
  endfunction

  // Polarity is applied as the last step before a value reaches the output
  // flops. The pins therefore come straight from registers, with no inverter
  // after them.
  function automatic logic [3:0] anode_level(input logic [1:0] i_idx);
    logic [3:0] onehot;
    onehot = 4'b0001 << i_idx;
    return ANODE_ACTIVE_LOW ? ~onehot : onehot;
  endfunction

  function automatic logic [6:0] seg_level(input logic [6:0] i_lit);
    return SEG_ACTIVE_LOW ? ~i_lit : i_lit;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [GCW-1:0]   r_guard_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_frame_buf;
  logic [3:0]       r_anodes;
  logic [6:0]       r_segments;
  logic             r_frame_done;
`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0]       r_high_idx;   // most significant nonzero digit of the frame
`endif

  // ---------------------------------------------------------------------------
  // Next-digit datapath. Only used on an advancing tick.
  // ---------------------------------------------------------------------------
  logic [1:0] w_next_idx;
  logic       w_wrap;
  logic       w_advance;
  logic [3:0] w_nibble;
  logic [6:0] w_lit;
`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] w_high_new;
  logic [1:0] w_high_use;
`endif

  // NOTE: every always_comb output is assigned on every path (here by full
  // case/default coverage) so that no latch is inferred.
  always_comb begin
    w_next_idx = r_idx + 2'd1;
    w_wrap     = (w_next_idx == 2'd0);
    // SHOW with no guard slots, or GUARD with the count exhausted, moves on
    // to the next digit.
    w_advance  = (r_state == ST_SHOW) ? (GUARD_TICKS == 0) : (r_guard_cnt == '0);
    // On the wrap the frame is being latched on this same edge. Digit0 is
    // therefore taken directly from the input and not from the stale buffer.
    case (w_next_idx)
      2'd0:    w_nibble = data_shown[3:0];
      2'd1:    w_nibble = r_frame_buf[7:4];
      2'd2:    w_nibble = r_frame_buf[11:8];
      default: w_nibble = r_frame_buf[15:12];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    if (data_shown[15:12] != 4'd0)     w_high_new = 2'd3;
    else if (data_shown[11:8] != 4'd0) w_high_new = 2'd2;
    else if (data_shown[7:4] != 4'd0)  w_high_new = 2'd1;
    else                               w_high_new = 2'd0;
    w_high_use = w_wrap ? w_high_new : r_high_idx;
    // Digit0 can never be above the highest digit, so it is never blanked.
    w_lit = (w_next_idx > w_high_use) ? 7'd0 : seg_decode(w_nibble);
  end
`else
  always_comb begin
    w_lit = seg_decode(w_nibble);
  end
`endif

  // ---------------------------------------------------------------------------
  // Scan FSM. All outputs are registered here. Nothing moves except on a
  // tick, apart from frame_done, which drops after one clock.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples the pre-edge values, whatever order the statements are written in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the frame buffer is reset together with the control flops. It is
      // small, and a defined value keeps the first frame deterministic.
      r_state      <= ST_GUARD;
      r_guard_cnt  <= '0;
      r_idx        <= 2'd3;        // first tick wraps to digit0 and latches
      r_frame_buf  <= '0;
      r_anodes     <= ANODE_OFF;
      r_segments   <= SEG_OFF;
      r_frame_done <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      r_high_idx   <= '0;
`endif
    end else begin
      r_frame_done <= 1'b0;
      if (next_data) begin
        if (w_advance) begin
          r_idx      <= w_next_idx;
          r_anodes   <= anode_level(w_next_idx);
          r_segments <= seg_level(w_lit);
          r_state    <= ST_SHOW;
          if (w_wrap) begin
            r_frame_buf  <= data_shown;
            r_frame_done <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            r_high_idx   <= w_high_new;
`endif
          end
        end else if (r_state == ST_SHOW) begin
          r_anodes    <= ANODE_OFF;
          r_segments  <= SEG_OFF;
          r_guard_cnt <= GUARD_LOAD;
          r_state     <= ST_GUARD;
        end else begin
          r_guard_cnt <= r_guard_cnt - GCW'(1);
        end
      end
    end
  end

  assign anodes     = r_anodes;
  assign segments   = r_segments;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_display_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scan
//
// Drives three instances of bcd_display_scan from one stimulus stream:
//   inst 0: defaults (1 guard slot, active-low anodes and segments)
//   inst 1: 2 guard slots, active-high anodes and segments
//   inst 2: no guard slots, active-low
// The reference model counts ticks since reset and derives the scan slot from
// the tick number. Each tick is either a digit slot or a guard slot, and a
// frame is latched in digit0's slot.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd_display_scan;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        next_data;
  logic [15:0] data_shown;
  logic [3:0]  an  [NI];
  logic [6:0]  seg [NI];
  logic        fd  [NI];

  always #5 clk = ~clk;

  bcd_display_scan dut_a (
    .clk(clk), .rst(rst), .next_data(next_data), .data_shown(data_shown),
    .anodes(an[0]), .segments(seg[0]), .frame_done(fd[0])
  );

  bcd_display_scan #(.GUARD_TICKS(2), .ANODE_ACTIVE_LOW(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(rst), .next_data(next_data), .data_shown(data_shown),
    .anodes(an[1]), .segments(seg[1]), .frame_done(fd[1])
  );

  bcd_display_scan #(.GUARD_TICKS(0)) dut_c (
    .clk(clk), .rst(rst), .next_data(next_data), .data_shown(data_shown),
    .anodes(an[2]), .segments(seg[2]), .frame_done(fd[2])
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          g_ticks [NI] = '{1, 2, 0};
  bit          a_low   [NI] = '{1'b1, 1'b0, 1'b1};
  bit          s_low   [NI] = '{1'b1, 1'b0, 1'b1};
  int          n_ticks [NI];
  logic [15:0] m_frame [NI];
  logic [3:0]  m_an    [NI];
  logic [6:0]  m_seg   [NI];
  logic        m_fd    [NI];

  int n_checks = 0;
  int n_fail   = 0;

  // Lit segments {g,f,e,d,c,b,a} of each character as drawn on the display.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  function automatic int high_digit(input logic [15:0] f);
    int h = 0;
    for (int k = 1; k < 4; k++)
      if (f[4*k +: 4] != 4'd0) h = k;
    return h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      n_ticks[i] = 0;
      m_frame[i] = '0;
      m_an[i]    = a_low[i] ? 4'hF : 4'h0;
      m_seg[i]   = s_low[i] ? 7'h7F : 7'h00;
      m_fd[i]    = 1'b0;
    end
  endtask

  task automatic model_clock(input logic nd, input logic [15:0] data);
    for (int i = 0; i < NI; i++) begin
      int per;
      int pos;
      int d;
      logic [3:0] onehot;
      logic [6:0] lit;
      m_fd[i] = 1'b0;
      if (nd) begin
        n_ticks[i]++;
        per = g_ticks[i] + 1;
        pos = (n_ticks[i] - 1) % (4 * per);
        if (pos % per == 0) begin
          d = pos / per;
          if (d == 0) begin
            m_frame[i] = data;
            m_fd[i]    = 1'b1;
          end
          onehot = 4'b0001 << d;
          m_an[i] = a_low[i] ? ~onehot : onehot;
          lit = glyph(m_frame[i][4*d +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
          if (d > high_digit(m_frame[i])) lit = 7'd0;
`endif
          m_seg[i] = s_low[i] ? ~lit : lit;
        end else begin
          m_an[i]  = a_low[i] ? 4'hF : 4'h0;
          m_seg[i] = s_low[i] ? 7'h7F : 7'h00;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_an%0d", tag, i),  16'(an[i]),  16'(m_an[i]));
      check($sformatf("%s_seg%0d", tag, i), 16'(seg[i]), 16'(m_seg[i]));
      check($sformatf("%s_fd%0d", tag, i),  16'(fd[i]),  16'(m_fd[i]));
    end
  endtask

  // Called just after a falling edge. Drives the inputs, lets one rising edge
  // pass, advances the model, and compares on the next falling edge.
  task automatic step(input logic nd, input string tag);
    next_data = nd;
    @(posedge clk);
    model_clock(nd, data_shown);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    next_data = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    for (int k = 0; k < 4; k++)
      w[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return w;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst        = 1'b1;
    next_data  = 1'b0;
    data_shown = 16'h0000;
    model_reset();
    @(negedge clk);
    check_all("por");
    check("por_an_const", 16'(an[0]), 16'h000F);
    rst = 1'b0;

    // Basic scan of 1234 with a guard slot between digits.
    data_shown = 16'h1234;
    step(1'b1, "t1");
    check("t1_an",  16'(an[0]),  16'(4'b1110));
    check("t1_seg", 16'(seg[0]), 16'(7'b0011001));
    check("t1_fd",  16'(fd[0]),  16'd1);
    step(1'b0, "hold");
    check("hold_fd", 16'(fd[0]), 16'd0);
    step(1'b1, "t2");
    check("t2_an",  16'(an[0]),  16'(4'b1111));
    check("t2_seg", 16'(seg[0]), 16'(7'b1111111));
    step(1'b1, "t3");
    check("t3_an",  16'(an[0]),  16'(4'b1101));
    check("t3_seg", 16'(seg[0]), 16'(7'b0110000));

    // A new value mid-frame must not disturb the rest of the current frame.
    data_shown = 16'h5678;
    step(1'b1, "t4");
    step(1'b1, "t5");
    check("mid_d2", 16'(seg[0]), 16'(7'b0100100));
    step(1'b1, "t6");
    step(1'b1, "t7");
    check("mid_d3", 16'(seg[0]), 16'(7'b1111001));
    step(1'b1, "t8");
    step(1'b1, "t9");
    check("new_d0",    16'(seg[0]), 16'(7'b0000000));
    check("new_d0_fd", 16'(fd[0]),  16'd1);

    // Non-BCD nibble shows a dash.
    do_reset("rst3");
    data_shown = 16'h00A0;
    for (int k = 0; k < 3; k++) step(1'b1, "dash");
    check("dash_an",  16'(an[0]),  16'(4'b1101));
    check("dash_seg", 16'(seg[0]), 16'(7'b0111111));

    // Async reset while a digit is lit and frame_done is high.
    do_reset("rst4a");
    data_shown = 16'h9876;
    step(1'b1, "pre");
    #2 rst = 1'b1;
    #1;
    check("async_an",  16'(an[0]),  16'(4'b1111));
    check("async_seg", 16'(seg[0]), 16'(7'b1111111));
    check("async_fd",  16'(fd[0]),  16'd0);
    model_reset();
    check_all("async");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, "g0");
    step(1'b1, "g1");
    // Async reset in the middle of a guard slot, then restart at digit0.
    do_reset("rst4b");
    check("guard_rst_an", 16'(an[0]), 16'(4'b1111));
    step(1'b1, "restart");
    check("restart_an", 16'(an[0]), 16'(4'b1110));
    check("restart_fd", 16'(fd[0]), 16'd1);
    check("restart_seg", 16'(seg[0]), 16'(7'b0000010));

    // Leading zeros.
    do_reset("rst5");
    data_shown = 16'h0050;
    step(1'b1, "lz_d0");
    check("lz_d0_seg", 16'(seg[0]), 16'(7'b1000000));
    step(1'b1, "lz");
    step(1'b1, "lz_d1");
    check("lz_d1_seg", 16'(seg[0]), 16'(7'b0010010));
    step(1'b1, "lz");
    step(1'b1, "lz_d2");
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_d2_seg", 16'(seg[0]), 16'(7'b1111111));
`else
    check("lz_d2_seg", 16'(seg[0]), 16'(7'b1000000));
`endif
    step(1'b1, "lz");
    step(1'b1, "lz_d3");
    check("lz_d3_an", 16'(an[0]), 16'(4'b0111));
`ifdef LEADING_ZERO_BLANK_EN
    check("lz_d3_seg", 16'(seg[0]), 16'(7'b1111111));
`else
    check("lz_d3_seg", 16'(seg[0]), 16'(7'b1000000));
`endif

    // No guard slots: next_data held high for five cycles.
    do_reset("rst6");
    data_shown = 16'h4321;
    begin
      logic [3:0] exp_an [5];
      logic       exp_fd [5];
      exp_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      exp_fd = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 5; k++) begin
        step(1'b1, "ng");
        check($sformatf("ng_an_%0d", k), 16'(an[2]), 16'(exp_an[k]));
        check($sformatf("ng_fd_%0d", k), 16'(fd[2]), 16'(exp_fd[k]));
      end
    end

    // Random traffic against the model.
    do_reset("rst_rand");
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) data_shown = rand_word();
      step(1'($urandom_range(0, 1)), "rnd");
      if (k == 200) do_reset("rst_mid");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
